// File: rtl/normalize.sv
// Two-stage normalizer: takes a two's-complement mantissa sum with a common exponent and
// produces a sign/magnitude result with the hidden one at bit WIDTH-1, plus zero/ovf/unf flags.
module normalize #(
   parameter int WIDTH = 52,
   parameter int EXP_W = 10,
   parameter int GUARD = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH+GUARD:0]   isum,
   input  logic [EXP_W-1:0]       iexp,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   osign,
   output logic [WIDTH-1:0]       omant,
   output logic [EXP_W-1:0]       oexp,
   output logic                   ozero,
   output logic                   oovf,
   output logic                   ounf
);

   localparam int MW = WIDTH + GUARD + 1;
   localparam int PW = $clog2(MW);
   localparam int SW = EXP_W + 2;
   localparam logic signed [SW-1:0] EMAX = SW'((1 << EXP_W) - 1);
   localparam logic signed [SW-1:0] EMIN = SW'(1);
   localparam logic [PW-1:0]        TOP  = PW'(WIDTH - 1);

   logic             s1_valid_q;
   logic             s1_sign_q;
   logic [MW-1:0]    s1_mag_q;
   logic [EXP_W-1:0] s1_exp_q;
   logic [MW-1:0]    mag_d;

   logic             ov_q, sign_q, zero_q, ovf_q, unf_q;
   logic [WIDTH-1:0] mant_q;
   logic [EXP_W-1:0] exp_q;

   logic             sign_d, zero_d, ovf_d, unf_d;
   logic [WIDTH-1:0] mant_d;
   logic [EXP_W-1:0] exp_d;
   logic [PW-1:0]    p, sh;
   logic [WIDTH-1:0] norm;
   logic signed [SW-1:0] d, e;
   logic             adv1;

   assign adv1     = !ov_q || out_ready;
   assign in_ready = !s1_valid_q || adv1;

   // The MW-bit negate wraps -2^(MW-1) onto itself, which is exactly its magnitude.
   assign mag_d = isum[MW-1] ? (~isum + MW'(1)) : isum;

   always_comb begin
      p = '0;
      for (int i = 0; i < MW; i++)
         if (s1_mag_q[i]) p = PW'(i);
   end

   always_comb begin
      sh   = '0;
      norm = '0;
      if (p >= TOP) begin
         sh   = p - TOP;
         norm = WIDTH'(s1_mag_q >> sh);
      end else begin
         sh   = TOP - p;
         norm = WIDTH'(s1_mag_q << sh);
      end
      d = $signed(SW'(p)) - $signed(SW'(TOP));
      e = $signed(SW'(s1_exp_q)) + d;
   end

   always_comb begin
      sign_d = s1_sign_q;
      zero_d = 1'b0;
      ovf_d  = 1'b0;
      unf_d  = 1'b0;
      mant_d = norm;
      exp_d  = EXP_W'(e);
      if (s1_mag_q == '0) begin
         sign_d = 1'b0;
         zero_d = 1'b1;
         mant_d = '0;
         exp_d  = '0;
      end else if (e > EMAX) begin
         ovf_d  = 1'b1;
         mant_d = '1;
         exp_d  = '1;
      end else if (e < EMIN) begin
         unf_d  = 1'b1;
         mant_d = '0;
         exp_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sign_q  <= 1'b0;
         s1_mag_q   <= '0;
         s1_exp_q   <= '0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sign_q <= isum[MW-1];
            s1_mag_q  <= mag_d;
            s1_exp_q  <= iexp;
         end
      end
   end

   // Output registers only load on advance, so a stalled result stays put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov_q   <= 1'b0;
         sign_q <= 1'b0;
         mant_q <= '0;
         exp_q  <= '0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else if (adv1) begin
         ov_q <= s1_valid_q;
         if (s1_valid_q) begin
            sign_q <= sign_d;
            mant_q <= mant_d;
            exp_q  <= exp_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
         end
      end
   end

   assign out_valid = ov_q;
   assign osign     = sign_q;
   assign omant     = mant_q;
   assign oexp      = exp_q;
   assign ozero     = zero_q;
   assign oovf      = ovf_q;
   assign ounf      = unf_q;

endmodule
